// File: rtl/uart_tx_stream.sv
// uart_tx_stream -- parametrised UART transmitter fed by a valid/ready stream.
//
// Serialises DATA_BITS-wide words as: start (0), data LSB-first, optional
// parity bit, STOP_BITS stop bits (1). Each bit lasts DIV clock cycles, where
// DIV = (CLK_HZ + BAUD/2) / BAUD.
//
// Optional feature macro: UART_TX_FIFO_EN
//    Undefined: tx_ready_o is combinational and high in IDLE and in the final
//               cycle of the last stop bit. The start bit appears one cycle
//               after the transfer.
//    Defined:   a FIFO_DEPTH-entry FIFO sits in front of the serialiser.
//               tx_ready_o is a registered !full. The serialiser pops the
//               head in IDLE or in the final stop cycle.
//
// Ports:
//    clk_i       system clock, rising edge
//    rst_ni      asynchronous active-low reset
//    tx_data_i   word to send, LSB first
//    tx_valid_i  producer offers tx_data_i
//    tx_ready_o  block accepts tx_data_i this cycle
//    uart_out_o  serial line, idle high (registered)
//    busy_o      frame in progress or data buffered

module uart_tx_stream #(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 uart_out_o,
   output logic                 busy_o
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   // Reject configurations the serialiser cannot honour at elaboration time.
   if (DIV < 2) begin : gDivCheck
      $error("uart_tx_stream: DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gDataCheck
      $error("uart_tx_stream: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : gParCheck
      $error("uart_tx_stream: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gStopCheck
      $error("uart_tx_stream: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          baudCnt_q, baudCnt_d;
   logic [3:0]             bitCnt_q, bitCnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic                   uartOut_q, uartOut_d;

   logic                   bitDone;
   logic                   lastStop;
   logic                   canStart;
   logic                   startFrame;
   logic                   loadFrame;
   logic [DATA_BITS-1:0]   loadData;

   // A new frame may begin when the line is idle or when the last stop bit
   // is in its final cycle, which gives back-to-back frames with no gap.
   assign bitDone  = (baudCnt_q == BAUD_LAST);
   assign lastStop = (state_q == ST_STOP) && bitDone && (bitCnt_q == STOP_LAST);
   assign canStart = (state_q == ST_IDLE) || lastStop;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gFifoCheck
      $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wrPtr_q, rdPtr_q;
   logic [AW:0]          count_q, count_d;
   logic                 ready_q;
   logic                 push, pop;

   // Ready is registered and only reflects fullness, so a push can never
   // land on a full FIFO. Push and pop in one cycle leave the count unchanged.
   assign push       = tx_valid_i && ready_q;
   assign pop        = (count_q != '0) && canStart;
   assign startFrame = pop;
   assign loadData   = mem_q[rdPtr_q];
   assign tx_ready_o = ready_q;
   assign busy_o     = (state_q != ST_IDLE) || (count_q != '0);

   // Occupancy after this cycle's push/pop, used for both count and ready.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, count and the registered ready flag. Pointers wrap
   // naturally because the depth is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wrPtr_q] <= tx_data_i;
   end
`else
   // Without buffering the stream handshake drives the serialiser directly.
   assign startFrame = tx_valid_i && canStart;
   assign loadData   = tx_data_i;
   assign tx_ready_o = canStart;
   assign busy_o     = (state_q != ST_IDLE);
`endif

   // Next-state logic. The baud counter free-runs 0..DIV-1 inside a frame and
   // is forced to zero in IDLE so every frame starts with a fresh bit period.
   // The line level is derived from the next state so uart_out_o can be a
   // plain register that resets high.
   always_comb begin
      state_d   = state_q;
      baudCnt_d = bitDone ? '0 : baudCnt_q + 1'b1;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      loadFrame = 1'b0;
      uartOut_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            baudCnt_d = '0;
            if (startFrame) begin
               state_d   = ST_START;
               loadFrame = 1'b1;
            end
         end
         ST_START: begin
            if (bitDone) begin
               state_d  = ST_DATA;
               bitCnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bitDone) begin
               shift_d = shift_q >> 1;
               if (bitCnt_q == DATA_LAST) begin
                  bitCnt_d = '0;
                  state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (bitDone) begin
               state_d  = ST_STOP;
               bitCnt_d = '0;
            end
         end
         ST_STOP: begin
            if (bitDone) begin
               if (bitCnt_q == STOP_LAST) begin
                  bitCnt_d = '0;
                  if (startFrame) begin
                     state_d   = ST_START;
                     loadFrame = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Capturing the word and its parity at frame start keeps the frame
      // immune to later changes on the input.
      if (loadFrame) begin
         baudCnt_d = '0;
         shift_d   = loadData;
         parity_d  = (PARITY == 1) ? ~(^loadData) : (^loadData);
      end

      case (state_d)
         ST_IDLE:   uartOut_d = 1'b1;
         ST_START:  uartOut_d = 1'b0;
         ST_DATA:   uartOut_d = shift_d[0];
         ST_PARITY: uartOut_d = parity_d;
         ST_STOP:   uartOut_d = 1'b1;
         default:   uartOut_d = 1'b1;
      endcase
   end

   // Serialiser state. Reset abandons any partial frame and drives the line
   // high immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         baudCnt_q <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         uartOut_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         uartOut_q <= uartOut_d;
      end
   end

   assign uart_out_o = uartOut_q;

endmodule
